// File: rtl/vsc_pkg.sv
// Shared types and constants for the vending session controller.
// The optional change-giving feature is selected with the VSC_CHANGE_EN macro
// in vending_session_ctrl; nothing in this package depends on it.
package vsc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_REFUND   = 2'd3
    } vsc_state_e;

    // Note codes reported by the acceptor
    localparam logic [1:0] NOTE_INVALID = 2'b00;
    localparam logic [1:0] NOTE_TWO     = 2'b01;
    localparam logic [1:0] NOTE_FIVE    = 2'b10;
    localparam logic [1:0] NOTE_TEN     = 2'b11;

    // Status encodings driven on SAIDA
    localparam logic [1:0] SAIDA_IDLE    = 2'b00;
    localparam logic [1:0] SAIDA_COLLECT = 2'b01;
    localparam logic [1:0] SAIDA_REFUND  = 2'b10;
    localparam logic [1:0] SAIDA_PAID    = 2'b11;

    // Credit value of a note code; an invalid note is worth nothing
    function automatic logic [4:0] note_value(input logic [1:0] code);
        note_value = 5'd0;
        case (code)
            NOTE_INVALID: note_value = 5'd0;
            NOTE_TWO:     note_value = 5'd2;
            NOTE_FIVE:    note_value = 5'd5;
            NOTE_TEN:     note_value = 5'd10;
            default:      note_value = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/vsc_timeout_cnt.sv
// Inactivity down-counter for the vending session controller.
// load presets TIMEOUT_CYC-1, enable counts down and holds at zero,
// zero flags that the count has run out.
module vsc_timeout_cnt #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic zero
);

    localparam int W = $clog2(TIMEOUT_CYC);
    localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: reload wins over decrement, and the count never wraps below zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/vending_session_ctrl.sv
// Session controller for the note-payment datapath: latches the product price,
// accumulates credit from accepted notes, runs the inactivity timeout and drives
// dispense or refund toward the mechanism.
// Build option: define VSC_CHANGE_EN to dispense with change on overpayment;
// without it an overpayment refunds the whole credit and CHANGE stays 0.
module vending_session_ctrl
    import vsc_pkg::*;
#(
    parameter int PRICE0      = 2,
    parameter int PRICE1      = 4,
    parameter int PRICE2      = 6,
    parameter int PRICE3      = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [1:0] PRODUTO,
    input  logic       CANCEL,
    input  logic       NOTE_VALID,
    input  logic [1:0] CEDULA,
    output logic       NOTE_READY,
    input  logic       DONE_ACK,
    output logic       DISPENSE,
    output logic       REFUND,
    output logic [4:0] CHANGE,
    output logic [4:0] CREDIT,
    output logic       TIMER,
    output logic [1:0] SAIDA
);

    vsc_state_e state_q, state_d;
    logic [3:0] price_q, price_d;
    logic [4:0] credit_q, credit_d;
    logic [4:0] change_q, change_d;
    logic       dispense_q, dispense_d;
    logic       refund_q, refund_d;
    logic       timer_pulse_q, timer_pulse_d;
    logic       note_ready_q, note_ready_d;
    logic [1:0] saida_q, saida_d;

    logic       tmr_load;
    logic       tmr_enable;
    logic       tmr_zero;
    logic       xfer;
    logic [4:0] new_credit;
    logic [4:0] price_ext;

    function automatic logic [3:0] price_of(input logic [1:0] code);
        price_of = 4'(PRICE0);
        case (code)
            2'b00:   price_of = 4'(PRICE0);
            2'b01:   price_of = 4'(PRICE1);
            2'b10:   price_of = 4'(PRICE2);
            2'b11:   price_of = 4'(PRICE3);
            default: price_of = 4'(PRICE0);
        endcase
    endfunction

    vsc_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (CLK),
        .rst    (RST),
        .load   (tmr_load),
        .enable (tmr_enable),
        .zero   (tmr_zero)
    );

    assign xfer       = NOTE_VALID && note_ready_q;
    assign new_credit = credit_q + note_value(CEDULA);
    assign price_ext  = {1'b0, price_q};

    // Session decisions: next state, credit/price/change updates and timer control
    always_comb begin
        state_d       = state_q;
        price_d       = price_q;
        credit_d      = credit_q;
        change_d      = change_q;
        timer_pulse_d = 1'b0;
        tmr_load      = 1'b0;
        tmr_enable    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d  = ST_COLLECT;
                    price_d  = price_of(PRODUTO);
                    credit_d = 5'd0;
                    change_d = 5'd0;
                    tmr_load = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (xfer) begin
                    credit_d = new_credit;
                    tmr_load = 1'b1;
                    if (new_credit >= price_ext) begin
`ifdef VSC_CHANGE_EN
                        state_d  = ST_DISPENSE;
                        change_d = new_credit - price_ext;
`else
                        state_d  = (new_credit == price_ext) ? ST_DISPENSE : ST_REFUND;
`endif
                    end else if (CANCEL) begin
                        state_d = (new_credit != 5'd0) ? ST_REFUND : ST_IDLE;
                    end
                end else if (CANCEL || tmr_zero) begin
                    timer_pulse_d = tmr_zero;
                    state_d       = (credit_q != 5'd0) ? ST_REFUND : ST_IDLE;
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            ST_DISPENSE, ST_REFUND: begin
                if (DONE_ACK) begin
                    state_d  = ST_IDLE;
                    credit_d = 5'd0;
                    change_d = 5'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs follow the state being entered
    always_comb begin
        dispense_d   = (state_d == ST_DISPENSE);
        refund_d     = (state_d == ST_REFUND);
        note_ready_d = (state_d == ST_COLLECT);
        saida_d      = SAIDA_IDLE;
        case (state_d)
            ST_IDLE:     saida_d = SAIDA_IDLE;
            ST_COLLECT:  saida_d = SAIDA_COLLECT;
            ST_DISPENSE: saida_d = SAIDA_PAID;
            ST_REFUND:   saida_d = SAIDA_REFUND;
            default:     saida_d = SAIDA_IDLE;
        endcase
    end

    // State and output registers; reset abandons any session without refund
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            price_q       <= 4'd0;
            credit_q      <= 5'd0;
            change_q      <= 5'd0;
            dispense_q    <= 1'b0;
            refund_q      <= 1'b0;
            timer_pulse_q <= 1'b0;
            note_ready_q  <= 1'b0;
            saida_q       <= SAIDA_IDLE;
        end else begin
            state_q       <= state_d;
            price_q       <= price_d;
            credit_q      <= credit_d;
            change_q      <= change_d;
            dispense_q    <= dispense_d;
            refund_q      <= refund_d;
            timer_pulse_q <= timer_pulse_d;
            note_ready_q  <= note_ready_d;
            saida_q       <= saida_d;
        end
    end

    assign NOTE_READY = note_ready_q;
    assign DISPENSE   = dispense_q;
    assign REFUND     = refund_q;
    assign CHANGE     = change_q;
    assign CREDIT     = credit_q;
    assign TIMER      = timer_pulse_q;
    assign SAIDA      = saida_q;

endmodule
